// File: rtl/reg_writeback_pkg.sv
// rtl/reg_writeback_pkg.sv - shared widths and write-record type for the register write-back front end
package reg_writeback_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_DATA_W-1:0] data;
    } wb_rec_t;
endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous FIFO holding long-latency write records
module wb_fifo
    import reg_writeback_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  wb_rec_t                pushRec,
    input  logic                   pop,
    output wb_rec_t                popRec,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    wb_rec_t        mem [DEPTH];
    logic [AW-1:0]  wrPtr;
    logic [AW-1:0]  rdPtr;
    logic           doPush;
    logic           doPop;

    assign full   = (count == (AW+1)'(DEPTH));
    assign empty  = (count == '0);
    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign popRec = mem[rdPtr];

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushRec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/reg_writeback.sv
// rtl/reg_writeback.sv - merges pipeline and long-latency results onto the register file write port
module reg_writeback
    import reg_writeback_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wb_en,
    input  logic [4:0]             wb_rd,
    input  logic [31:0]            wb_data,
    input  logic                   lq_valid,
    output logic                   lq_ready,
    input  logic [4:0]             lq_rd,
    input  logic [31:0]            lq_data,
    input  logic                   alloc_en,
    input  logic [4:0]             alloc_rd,
    input  logic [4:0]             chk_rs,
    input  logic [4:0]             chk_rt,
    output logic                   rs_busy,
    output logic                   rt_busy,
    output logic                   RegWrite,
    output logic [4:0]             WriteReg,
    output logic [31:0]            WriteData,
    output logic [$clog2(DEPTH):0] fifo_count
);
    logic        fifoFull;
    logic        fifoEmpty;
    logic        push;
    logic        pop;
    logic        wbTake;
    wb_rec_t     pushRec;
    wb_rec_t     headRec;
    logic [31:0] pending;
    logic [31:0] pendingNext;

    assign lq_ready = !fifoFull;
    assign push     = lq_valid && lq_ready;
    assign pushRec  = '{rd: lq_rd, data: lq_data};
    assign wbTake   = wb_en && (wb_rd != '0);
    assign pop      = !wbTake && !fifoEmpty;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pushRec (pushRec),
        .pop     (pop),
        .popRec  (headRec),
        .full    (fifoFull),
        .empty   (fifoEmpty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWrite  <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
        end else if (wbTake) begin
            RegWrite  <= 1'b1;
            WriteReg  <= wb_rd;
            WriteData <= wb_data;
        end else if (pop) begin
            // An rd==0 record still consumes the port slot but must not write.
            RegWrite  <= (headRec.rd != '0);
            WriteReg  <= headRec.rd;
            WriteData <= headRec.data;
        end else begin
            RegWrite  <= 1'b0;
        end
    end

    // Clear on pop is applied before set so a same-cycle re-allocation wins.
    always_comb begin
        pendingNext = pending;
        if (pop) pendingNext[headRec.rd] = 1'b0;
        if (alloc_en && (alloc_rd != '0)) pendingNext[alloc_rd] = 1'b1;
        pendingNext[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else        pending <= pendingNext;
    end

    assign rs_busy = pending[chk_rs];
    assign rt_busy = pending[chk_rt];
endmodule

// File: tb/tb_reg_writeback.sv
// tb/tb_reg_writeback.sv - directed self-checking bench for reg_writeback
module tb_reg_writeback;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        lq_valid;
    logic        lq_ready;
    logic [4:0]  lq_rd;
    logic [31:0] lq_data;
    logic        alloc_en;
    logic [4:0]  alloc_rd;
    logic [4:0]  chk_rs;
    logic [4:0]  chk_rt;
    logic        rs_busy;
    logic        rt_busy;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [2:0]  fifo_count;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    reg_writeback #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb_en      (wb_en),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .lq_valid   (lq_valid),
        .lq_ready   (lq_ready),
        .lq_rd      (lq_rd),
        .lq_data    (lq_data),
        .alloc_en   (alloc_en),
        .alloc_rd   (alloc_rd),
        .chk_rs     (chk_rs),
        .chk_rt     (chk_rt),
        .rs_busy    (rs_busy),
        .rt_busy    (rt_busy),
        .RegWrite   (RegWrite),
        .WriteReg   (WriteReg),
        .WriteData  (WriteData),
        .fifo_count (fifo_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are then stable for sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; wb_en = 1'b0; wb_rd = '0; wb_data = '0;
        lq_valid = 1'b1; lq_rd = 5'd3; lq_data = 32'h3333_3333;
        alloc_en = 1'b0; alloc_rd = '0; chk_rs = '0; chk_rt = '0;
        step(); step();
        check("rst_lq_ready", lq_ready, 1);
        check("rst_regwrite", RegWrite, 0);
        check("rst_count", fifo_count, 0);
        check("rst_writereg", WriteReg, 0);
        check("rst_writedata", WriteData, 0);
        lq_valid = 1'b0;
        rst_n = 1'b1;

        // Plain pipeline write
        wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
        step();
        check("wb_regwrite", RegWrite, 1);
        check("wb_writereg", WriteReg, 5);
        check("wb_writedata", WriteData, 32'hDEAD_BEEF);
        wb_en = 1'b0;
        step();
        check("idle_regwrite", RegWrite, 0);
        check("idle_hold_reg", WriteReg, 5);
        check("idle_hold_data", WriteData, 32'hDEAD_BEEF);

        // Long-latency result blocked by pipeline writes, busy until it drains
        alloc_en = 1'b1; alloc_rd = 5'd8; chk_rs = 5'd8;
        step();
        alloc_en = 1'b0;
        check("alloc8_busy", rs_busy, 1);
        wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'h1;
        lq_valid = 1'b1; lq_rd = 5'd8; lq_data = 32'h1234;
        step();
        lq_valid = 1'b0;
        check("blk_count", fifo_count, 1);
        check("blk_busy1", rs_busy, 1);
        check("blk_wreg1", WriteReg, 1);
        wb_rd = 5'd2; wb_data = 32'h2;
        step();
        check("blk_busy2", rs_busy, 1);
        check("blk_wreg2", WriteReg, 2);
        wb_rd = 5'd3; wb_data = 32'h3;
        step();
        check("blk_busy3", rs_busy, 1);
        check("blk_count3", fifo_count, 1);
        wb_en = 1'b0;
        step();
        check("drain8_regwrite", RegWrite, 1);
        check("drain8_wreg", WriteReg, 8);
        check("drain8_data", WriteData, 32'h1234);
        check("drain8_busy", rs_busy, 0);
        check("drain8_count", fifo_count, 0);

        // Fill the FIFO while the pipeline owns the port
        wb_en = 1'b1; wb_rd = 5'd10; wb_data = 32'hA;
        lq_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            lq_rd = 5'(11 + i); lq_data = 32'hA0 + 32'(i);
            step();
        end
        check("full_count", fifo_count, 4);
        check("full_ready", lq_ready, 0);
        lq_rd = 5'd15; lq_data = 32'hBAD;
        step();
        check("full_ignored_count", fifo_count, 4);
        check("full_ignored_ready", lq_ready, 0);
        wb_en = 1'b0; lq_valid = 1'b0;
        step();
        check("pop0_wreg", WriteReg, 11);
        check("pop0_data", WriteData, 32'hA0);
        check("pop0_count", fifo_count, 3);
        check("pop0_ready", lq_ready, 1);
        step();
        check("pop1_wreg", WriteReg, 12);
        check("pop1_data", WriteData, 32'hA1);
        step();
        check("pop2_wreg", WriteReg, 13);
        check("pop2_data", WriteData, 32'hA2);
        step();
        check("pop3_wreg", WriteReg, 14);
        check("pop3_data", WriteData, 32'hA3);
        check("pop3_count", fifo_count, 0);
        step();
        check("empty_regwrite", RegWrite, 0);

        // rd==0 entry consumes a slot without writing; alloc of r0 never busies
        lq_valid = 1'b1; lq_rd = 5'd0; lq_data = 32'h55;
        alloc_en = 1'b1; alloc_rd = 5'd0; chk_rs = 5'd0; chk_rt = 5'd0;
        step();
        lq_valid = 1'b0; alloc_en = 1'b0;
        check("r0_no_fallthrough", RegWrite, 0);
        check("r0_count1", fifo_count, 1);
        check("r0_alloc_rs", rs_busy, 0);
        step();
        check("r0_pop_regwrite", RegWrite, 0);
        check("r0_pop_count", fifo_count, 0);

        // Re-allocation of r9 on the cycle its old result pops keeps it busy
        alloc_en = 1'b1; alloc_rd = 5'd9; chk_rt = 5'd9;
        step();
        alloc_en = 1'b0;
        check("alloc9_busy", rt_busy, 1);
        lq_valid = 1'b1; lq_rd = 5'd9; lq_data = 32'h99;
        step();
        lq_valid = 1'b0;
        alloc_en = 1'b1; alloc_rd = 5'd9;
        step();
        alloc_en = 1'b0;
        check("r9_pop_wreg", WriteReg, 9);
        check("r9_pop_regwrite", RegWrite, 1);
        check("r9_set_wins", rt_busy, 1);

        // Reset in the middle of a drain
        wb_en = 1'b1; wb_rd = 5'd2; wb_data = 32'h22; lq_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            lq_rd = 5'(20 + i); lq_data = 32'hC0 + 32'(i);
            step();
        end
        wb_en = 1'b0; lq_valid = 1'b0;
        step();
        check("md_pop_wreg", WriteReg, 20);
        check("md_count", fifo_count, 2);
        rst_n = 1'b0;
        #1;
        check("md_rst_regwrite", RegWrite, 0);
        check("md_rst_wreg", WriteReg, 0);
        check("md_rst_data", WriteData, 0);
        check("md_rst_count", fifo_count, 0);
        check("md_rst_ready", lq_ready, 1);
        check("md_rst_busy", rt_busy, 0);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_count", fifo_count, 0);
        check("post_rst_regwrite", RegWrite, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/reg_writeback.md
# reg_writeback

Write-side front end for the 32×32 MIPS register file: merges the in-order pipeline write-back stream with results from long-latency units (load misses, multiply/divide) onto the file's single write port. Long-latency results are buffered in a small FIFO and drained in idle write-port cycles. A scoreboard of outstanding long-latency destinations tells decode which source registers are not yet valid. The block drives the register file's RegWrite/WriteReg/WriteData inputs from registered outputs.

## Interface
- DEPTH, 4, long-latency result FIFO entries (power of two, ≥2)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- wb_en  in  1  pipeline write-back valid; no backpressure
- wb_rd  in  5  pipeline destination register
- wb_data  in  32  pipeline result
- lq_valid  in  1  long-latency result valid
- lq_ready  out  1  FIFO can accept (count < DEPTH)
- lq_rd  in  5  long-latency destination register
- lq_data  in  32  long-latency result
- alloc_en  in  1  decode issued a long-latency op
- alloc_rd  in  5  its destination register
- chk_rs, chk_rt  in  5 each  decode source registers to check
- rs_busy, rt_busy  out  1 each  source has an outstanding long-latency write
- RegWrite  out  1  register file write enable
- WriteReg  out  5  register file write address
- WriteData  out  32  register file write data
- fifo_count  out  clog2(DEPTH)+1  current FIFO occupancy

## Operation
- Enqueue: lq_valid && lq_ready pushes {lq_rd, lq_data}. lq_ready depends only on registered count; no same-cycle pop credit when full.
- Write-port arbitration each cycle, pipeline first:
  - wb_en && wb_rd != 0: load output register with pipeline write; FIFO holds.
  - else FIFO non-empty: pop head into output register.
  - else RegWrite <= 0; WriteReg/WriteData hold previous value.
- Entries with rd == 0 are accepted and popped but produce RegWrite = 0 for that cycle (port slot consumed).
- Scoreboard: 32-bit pending vector.
  - alloc_en && alloc_rd != 0 sets pending[alloc_rd].
  - FIFO pop clears pending[popped rd].
  - Set and clear of same register in one cycle: set wins.
  - pending[0] is constant 0.
- rs_busy = pending[chk_rs], rt_busy = pending[chk_rt]; combinational from registered state.
- Decode stalls on busy; this block does not reorder or detect WAW between streams.
- FIFO ordering strictly first-in first-out.

## Timing
- Reset (async assert, sync-to-clk deassert handled upstream): RegWrite 0, WriteReg 0, WriteData 0, pending all 0, FIFO empty, fifo_count 0, lq_ready 1, rs_busy/rt_busy 0.
- Reset mid-operation discards all buffered entries and pending bits.
- Latency: input accepted at edge N → RegWrite/WriteReg/WriteData valid during cycle N+1; register file commits at edge N+1.
- Busy clears at the same edge the output register is loaded; in that following cycle the register file's same-cycle write bypass supplies the value, so no extra stall cycle.
- Simultaneous push and pop when non-empty and not full: count unchanged.
- Push to empty FIFO in a cycle with no pipeline write: entry pops no earlier than the next cycle (no fall-through).
- Pointers wrap modulo DEPTH.

## Structure
- Shared package: REG_ADDR_W = 5, REG_DATA_W = 32, DEPTH default, write-record type {rd, data}.
- One sub-module: wb_fifo (synchronous FIFO, push/pop/full/empty/count, async active-low reset).
- Scoreboard, arbitration and output register live in reg_writeback.

## Test plan
- Reset with lq_valid high → lq_ready = 1, RegWrite = 0, fifo_count = 0; no push until rst_n rises.
- wb_en=1, wb_rd=5, wb_data=0xDEADBEEF at edge N → cycle N+1 RegWrite=1, WriteReg=5, WriteData=0xDEADBEEF.
- alloc_rd=8, then lq push {8, 0x1234} while wb_en=1 for 3 cycles → rs_busy(chk_rs=8)=1 throughout; after wb_en drops, next cycle WriteReg=8, WriteData=0x1234, rs_busy=0.
- Push 4 entries with wb_en held high → fifo_count=4, lq_ready=0; lq_valid high ignored; release wb_en → entries drain in order over 4 cycles, lq_ready=1 after first pop.
- Long-latency entry with rd=0 → popped, RegWrite=0 that cycle, fifo_count decrements; alloc_rd=0 never raises busy.
- alloc_rd=9 in the same cycle an entry for reg 9 pops → pending[9] remains 1; rst_n pulsed low mid-drain → all outputs return to reset values immediately.
